krake_port_rx: RTL

Wishbone-slave UART receiver peripheral, the receive-side counterpart of the `krake_port_tx2` transmitter in the Die Datenkrake port fabric. It samples one serial line with 16x oversampling and frames 8N1 characters. It buffers received bytes and exposes them through the same 8-bit Wishbone register interface the TX block uses. In the port bench it consumes the TX block's serial output via the `ch_in` loopback.

---
 rtl/krake_port_rx_pkg.sv | 9 +
 rtl/uart_rx_core.sv | 65 ++++++
 rtl/krake_port_rx.sv | 99 +++++++++
 3 files changed

// File: rtl/krake_port_rx_pkg.sv
// krake_port_rx_pkg: register addresses and status bit indices shared by the UART RX peripheral.
package krake_port_rx_pkg;
    localparam logic [4:0] UART_RX_DATA   = 5'h00;
    localparam logic [4:0] UART_RX_STATUS = 5'h01;
    localparam int ST_VALID   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_FERR    = 2;
    localparam int ST_FULL    = 3;
endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: rx synchronizer, 16x tick divider and 8N1 framing FSM.
module uart_rx_core #(
    parameter int TICK_DIV = 27
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_stb_o,
    output logic       ferr_stb_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BRK   = 3'd4;
    logic        s1, s2, s3;
    logic [2:0]  st;
    logic [15:0] tcnt;
    logic [3:0]  scnt;
    logic [2:0]  bcnt;
    logic        tick;
    assign tick = (st != S_IDLE) && (tcnt == 16'(TICK_DIV - 1));
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {s3, s2, s1} <= 3'b111;
            st           <= S_IDLE;
            tcnt         <= '0;
            scnt         <= '0;
            bcnt         <= '0;
            byte_o       <= '0;
            byte_stb_o   <= 1'b0;
            ferr_stb_o   <= 1'b0;
        end else begin
            {s3, s2, s1} <= {s2, s1, rx_i};
            byte_stb_o   <= 1'b0;
            ferr_stb_o   <= 1'b0;
            tcnt         <= (st == S_IDLE || tick) ? '0 : tcnt + 16'd1;
            if (tick) scnt <= scnt + 4'd1;
            case (st)
                S_IDLE: if (s3 && !s2) begin
                    st   <= S_START;
                    scnt <= '0;
                end
                S_START: if (tick && scnt == 4'd7) begin
                    st   <= s2 ? S_IDLE : S_DATA;
                    scnt <= '0;
                    bcnt <= '0;
                end
                // scnt wraps every 16 ticks, so 15 lands on each later mid-bit
                S_DATA: if (tick && scnt == 4'd15) begin
                    byte_o <= {s2, byte_o[7:1]};
                    bcnt   <= bcnt + 3'd1;
                    if (bcnt == 3'd7) st <= S_STOP;
                end
                S_STOP: if (tick && scnt == 4'd15) begin
                    byte_stb_o <= s2;
                    ferr_stb_o <= !s2;
                    st         <= s2 ? S_IDLE : S_BRK;
                end
                default: if (s2) st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/krake_port_rx.sv
// krake_port_rx: Wishbone UART receiver with status flags and receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module krake_port_rx
    import krake_port_rx_pkg::*;
#(
    parameter int TICK_DIV   = 27,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stb_i,
    input  logic       we_i,
    input  logic [4:0] adr_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    input  logic       rx_i,
    output logic       irq_o
);
    logic [7:0] rx_byte, head, status, rd;
    logic       byte_stb, ferr_stb;
    logic       acc, pop, w1c, push_ok;
    logic       valid, full, ovr, ferr;
    logic       unused;
    uart_rx_core #(.TICK_DIV(TICK_DIV)) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_i       (rx_i),
        .byte_o     (rx_byte),
        .byte_stb_o (byte_stb),
        .ferr_stb_o (ferr_stb)
    );
    assign acc     = stb_i && !ack_o;
    assign pop     = acc && !we_i && adr_i == UART_RX_DATA && valid;
    assign w1c     = acc && we_i && adr_i == UART_RX_STATUS;
    assign push_ok = byte_stb && (!full || pop);
    assign irq_o   = valid;
    assign unused  = ^{dat_i[7:3], dat_i[0], 1'(FIFO_DEPTH)};
`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    assign valid = cnt != '0;
    assign full  = cnt == CW'(FIFO_DEPTH);
    assign head  = mem[rp];
    always_ff @(posedge clk_i) if (push_ok) mem[wp] <= rx_byte;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + CW'(push_ok) - CW'(pop);
        end
    end
`else
    logic [7:0] hold;
    logic       vld;
    assign valid = vld;
    assign full  = vld;
    assign head  = hold;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold <= '0;
            vld  <= 1'b0;
        end else begin
            if (push_ok) hold <= rx_byte;
            vld <= push_ok || (vld && !pop);
        end
    end
`endif
    always_comb begin
        status           = 8'h00;
        status[ST_VALID] = valid;
        status[ST_OVERRUN] = ovr;
        status[ST_FERR]  = ferr;
        status[ST_FULL]  = full;
        rd = adr_i == UART_RX_DATA ? (valid ? head : 8'h00) :
             adr_i == UART_RX_STATUS ? status : 8'h00;
    end
    // a flag set in the same cycle as its W1C clear wins
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
            dat_o <= 8'h00;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            ack_o <= acc;
            dat_o <= acc ? rd : 8'h00;
            ovr   <= (byte_stb && !push_ok) || (ovr && !(w1c && dat_i[ST_OVERRUN]));
            ferr  <= ferr_stb || (ferr && !(w1c && dat_i[ST_FERR]));
        end
    end
endmodule
